// File: rtl/sm3_msg_hash_if.sv
// Start/busy/done request bundle for the fixed-length SM3 hasher.
// The master side issues requests; the hasher is the slave.
interface sm3_msg_hash_if #(
    parameter int MSG_BITS = 512
);
    localparam int NBLK  = (MSG_BITS + 65 + 511) / 512;
    localparam int CNT_W = $clog2(NBLK + 1);

    logic                start;
    logic [MSG_BITS-1:0] msg;
    logic                busy;
    logic                done;
    logic [255:0]        hash_value;
    logic [CNT_W-1:0]    blk_idx;

    modport master (
        output start, msg,
        input  busy, done, hash_value, blk_idx
    );

    modport slave (
        input  start, msg,
        output busy, done, hash_value, blk_idx
    );
endinterface

// File: rtl/sm3_msg_hash.sv
// SM3 digest of a fixed-length message: padding built at elaboration,
// one iterative compression core chained across all 512-bit blocks.
module sm3_cf (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] v_in,
    input  logic [511:0] blk,
    output logic         fin,
    output logic [255:0] hash
);
    typedef enum logic [1:0] {C_IDLE, C_CALC, C_DONE} cst_t;

    cst_t         st;
    logic [5:0]   j;
    logic [31:0]  w [16];
    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [255:0] v;
    logic [31:0]  tj, a12, ss1, ss2, ff, gg, tt1, tt2, wn;
    logic         lo;

    function automatic logic [31:0] rotl(input logic [31:0] x,
                                         input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
    endfunction

    // w is a 16-word sliding window: w[0] is W[j], w[15] is W[j+15]
    always_comb begin
        lo  = (j[5:4] == 2'b00);
        tj  = lo ? 32'h79cc4519 : 32'h7a879d8a;
        a12 = rotl(a, 5'd12);
        ss1 = rotl(a12 + e + rotl(tj, j[4:0]), 5'd7);
        ss2 = ss1 ^ a12;
        ff  = lo ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
        gg  = lo ? (e ^ f ^ g) : ((e & f) | (~e & g));
        tt1 = ff + d + ss2 + (w[0] ^ w[4]);
        tt2 = gg + h + ss1 + w[0];
        wn  = p1(w[0] ^ w[7] ^ rotl(w[13], 5'd15))
            ^ rotl(w[3], 5'd7) ^ w[10];
    end

    assign hash = v ^ {a, b, c, d, e, f, g, h};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st  <= C_IDLE;
            j   <= '0;
            fin <= 1'b0;
        end else begin
            fin <= 1'b0;
            unique case (st)
                C_IDLE: if (start) begin
                    st <= C_CALC;
                    j  <= '0;
                end
                C_CALC: begin
                    j <= j + 6'd1;
                    if (j == 6'd63) begin
                        st  <= C_DONE;
                        fin <= 1'b1;
                    end
                end
                C_DONE:  st <= C_IDLE;
                default: st <= C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (st == C_IDLE && start) begin
            v <= v_in;
            {a, b, c, d, e, f, g, h} <= v_in;
            for (int i = 0; i < 16; i++)
                w[i] <= blk[511-32*i -: 32];
        end else if (st == C_CALC) begin
            d <= c;
            c <= rotl(b, 5'd9);
            b <= a;
            a <= tt1;
            h <= g;
            g <= rotl(f, 5'd19);
            f <= e;
            e <= p0(tt2);
            for (int i = 0; i < 15; i++)
                w[i] <= w[i+1];
            w[15] <= wn;
        end
    end
endmodule

module sm3_msg_hash #(
    parameter int MSG_BITS = 512
) (
    input logic           clk,
    input logic           reset,
    sm3_msg_hash_if.slave bus
);
    localparam int NBLK  = (MSG_BITS + 65 + 511) / 512;
    localparam int CNT_W = $clog2(NBLK + 1);
    localparam int PADW  = NBLK * 512;
    localparam int ZW    = PADW - MSG_BITS - 65;
    localparam logic [255:0] IV0 =
        256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;

    typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

    state_t              state;
    logic [MSG_BITS-1:0] msg_q;
    logic [255:0]        iv;
    logic [255:0]        cf_hash;
    logic                cf_start;
    logic                cf_end;
    logic [PADW-1:0]     padded;
    logic [511:0]        blk;
    logic [CNT_W-1:0]    blk_idx;
    logic                busy;
    logic                done;
    logic [255:0]        hash_value;

    assign padded = {msg_q, 1'b1, {ZW{1'b0}}, 64'(MSG_BITS)};

    always_comb begin
        blk = '0;
        for (int k = 0; k < NBLK; k++)
            if (blk_idx == CNT_W'(k))
                blk = padded[PADW-1-512*k -: 512];
    end

    sm3_cf u_cf (
        .clk   (clk),
        .rst_n (~reset),
        .start (cf_start),
        .v_in  (iv),
        .blk   (blk),
        .fin   (cf_end),
        .hash  (cf_hash)
    );

    // cf_start rises one cycle into RUN and drops on cf_end,
    // so the core always sees a low cycle between blocks
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            hash_value <= '0;
            blk_idx    <= '0;
            iv         <= IV0;
            cf_start   <= 1'b0;
            msg_q      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (bus.start) begin
                    msg_q   <= bus.msg;
                    iv      <= IV0;
                    blk_idx <= '0;
                    busy    <= 1'b1;
                    state   <= RUN;
                end
                RUN: if (cf_end) begin
                    iv       <= cf_hash;
                    cf_start <= 1'b0;
                    if (blk_idx == CNT_W'(NBLK - 1)) begin
                        state <= FIN;
                    end else begin
                        blk_idx <= blk_idx + CNT_W'(1);
                        state   <= GAP;
                    end
                end else begin
                    cf_start <= 1'b1;
                end
                GAP: begin
                    cf_start <= 1'b1;
                    state    <= RUN;
                end
                FIN: begin
                    hash_value <= iv;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    blk_idx    <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.hash_value = hash_value;
    assign bus.blk_idx    = blk_idx;
endmodule

// File: tb/tb_sm3_msg_hash.sv
// Directed bench for sm3_msg_hash: one-block (24-bit) and
// two-block (512-bit) instances, known digests and handshake corners.
`timescale 1ns/1ps
module tb_sm3_msg_hash;
    localparam logic [255:0] IV0 =
        256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
    localparam logic [255:0] H_ABC =
        256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
    localparam logic [255:0] H_ABCD =
        256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;
    localparam logic [511:0] ABCD = {16{32'h61626364}};
    // core latency from cf_start rising to cf_end: load + 64 rounds
    localparam int LCF = 65;
    localparam int LAT1 = 1 * (LCF + 2) + 1;
    localparam int LAT2 = 2 * (LCF + 2) + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sm3_msg_hash_if #(.MSG_BITS(24))  if24  ();
    sm3_msg_hash_if #(.MSG_BITS(512)) if512 ();

    sm3_msg_hash #(.MSG_BITS(24)) u24 (
        .clk   (clk),
        .reset (reset),
        .bus   (if24)
    );

    sm3_msg_hash #(.MSG_BITS(512)) u512 (
        .clk   (clk),
        .reset (reset),
        .bus   (if512)
    );

    int n_chk = 0;
    int n_err = 0;
    int dn24  = 0;
    int dn512 = 0;

    always @(negedge clk) begin
        if (if24.done)  dn24++;
        if (if512.done) dn512++;
    end

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int s;
        s = n % 32;
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] pp0(input logic [31:0] x);
        return x ^ rl(x, 9) ^ rl(x, 17);
    endfunction

    function automatic logic [31:0] pp1(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    // textbook compression: full 68-word expansion, then 64 rounds
    function automatic logic [255:0] cf_ref(input logic [255:0] v,
                                            input logic [511:0] m);
        logic [31:0] w [68];
        logic [31:0] ra, rb, rc, rd, re, rf, rg, rh;
        logic [31:0] t, s1, s2, t1, t2, fv, gv;
        for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
        for (int i = 16; i < 68; i++)
            w[i] = pp1(w[i-16] ^ w[i-9] ^ rl(w[i-3], 15))
                 ^ rl(w[i-13], 7) ^ w[i-6];
        {ra, rb, rc, rd, re, rf, rg, rh} = v;
        for (int k = 0; k < 64; k++) begin
            t  = (k < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            s1 = rl(rl(ra, 12) + re + rl(t, k), 7);
            s2 = s1 ^ rl(ra, 12);
            fv = (k < 16) ? (ra ^ rb ^ rc)
                          : ((ra & rb) | (ra & rc) | (rb & rc));
            gv = (k < 16) ? (re ^ rf ^ rg) : ((re & rf) | (~re & rg));
            t1 = fv + rd + s2 + (w[k] ^ w[k+4]);
            t2 = gv + rh + s1 + w[k];
            rd = rc; rc = rl(rb, 9); rb = ra; ra = t1;
            rh = rg; rg = rl(rf, 19); rf = re; re = pp0(t2);
        end
        return v ^ {ra, rb, rc, rd, re, rf, rg, rh};
    endfunction

    // mode 0 plain, 1 scramble msg every cycle, 2 re-pulse start in RUN
    task automatic run512(input int mode, output int lat, output int b0,
                          output int b1, output int gaps);
        @(posedge clk);
        #1 if512.start = 1'b1;
        if512.msg = ABCD;
        @(posedge clk);
        #1 if512.start = 1'b0;
        lat = 0; gaps = 0; b0 = -1; b1 = -1;
        do begin
            if (mode != 0)
                for (int i = 0; i < 16; i++)
                    if512.msg[32*i +: 32] = $urandom();
            if (mode == 2) if512.start = (lat == 5);
            @(posedge clk);
            #1 lat++;
            if (lat == 10)  b0 = int'(if512.blk_idx);
            if (lat == 100) b1 = int'(if512.blk_idx);
            if (!if512.done && !if512.busy) gaps++;
        end while (!if512.done && lat < 400);
        if512.start = 1'b0;
    endtask

    task automatic case512(input string tag, input int mode);
        int lat, b0, b1, gaps, d0;
        d0 = dn512;
        run512(mode, lat, b0, b1, gaps);
        chk({tag, "_lat"}, lat, LAT2);
        chk({tag, "_hash"}, if512.hash_value, H_ABCD);
        chk({tag, "_blk0"}, b0, 0);
        chk({tag, "_blk1"}, b1, 1);
        chk({tag, "_busy_gaps"}, gaps, 0);
        chk({tag, "_busy_at_done"}, if512.busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_done_cnt"}, dn512 - d0, 1);
        chk({tag, "_hash_held"}, if512.hash_value, H_ABCD);
        chk({tag, "_blk_idle"}, if512.blk_idx, 0);
    endtask

    initial begin
        logic [255:0] h_abd;
        logic [255:0] held;
        int lat;
        int d0;
        h_abd = cf_ref(IV0, {24'h616264, 1'b1, 423'd0, 64'd24});
        if24.start = 1'b0;  if24.msg = '0;
        if512.start = 1'b0; if512.msg = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_busy24", if24.busy, 0);
        chk("rst_done24", if24.done, 0);
        chk("rst_hash24", if24.hash_value, 0);
        chk("rst_blk24", if24.blk_idx, 0);
        chk("rst_busy512", if512.busy, 0);
        chk("rst_done512", if512.done, 0);
        chk("rst_hash512", if512.hash_value, 0);
        chk("rst_blk512", if512.blk_idx, 0);

        // one-block "abc"
        d0 = dn24;
        @(posedge clk);
        #1 if24.start = 1'b1;
        if24.msg = 24'h616263;
        @(posedge clk);
        #1 if24.start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!if24.done && lat < 400);
        chk("c1_lat", lat, LAT1);
        chk("c1_hash", if24.hash_value, H_ABC);
        chk("c1_busy_at_done", if24.busy, 0);
        @(posedge clk);
        #1 chk("c1_done_cnt", dn24 - d0, 1);

        case512("c2", 0);
        case512("c3", 1);
        case512("c4", 2);

        // reset during block 1 abandons the hash
        d0 = dn512;
        @(posedge clk);
        #1 if512.start = 1'b1;
        if512.msg = ABCD;
        @(posedge clk);
        #1 if512.start = 1'b0;
        repeat (100) @(posedge clk);
        #1 chk("c5_in_blk1", if512.blk_idx, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("c5_busy", if512.busy, 0);
        chk("c5_done", if512.done, 0);
        chk("c5_hash", if512.hash_value, 0);
        chk("c5_blk", if512.blk_idx, 0);
        repeat (200) @(posedge clk);
        #1 chk("c5_no_done", dn512 - d0, 0);
        case512("c5b", 0);

        // start held high: "abc" then "abd" back to back
        d0 = dn24;
        held = '0;
        @(posedge clk);
        #1 if24.start = 1'b1;
        if24.msg = 24'h616263;
        @(posedge clk);
        #1 if24.msg = 24'h616264;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!if24.done && lat < 400);
        chk("c6_lat1", lat, LAT1);
        chk("c6_hash1", if24.hash_value, H_ABC);
        @(posedge clk);
        #1 if24.start = 1'b0;
        lat++;
        chk("c6_busy2", if24.busy, 1);
        do begin
            @(posedge clk);
            #1 lat++;
            if (lat == 100) held = if24.hash_value;
        end while (!if24.done && lat < 400);
        chk("c6_lat2", lat, 2 * LAT1 + 1);
        chk("c6_held", held, H_ABC);
        chk("c6_hash2", if24.hash_value, h_abd);
        repeat (5) @(posedge clk);
        #1 chk("c6_done_cnt", dn24 - d0, 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
